// File: rtl/usr_deser.sv
// -----------------------------------------------------------------------------
// usr_deser
// Serial-to-parallel receiver for the bit stream shifted out of a universal
// shift register. Bits are taken one per strobe and assembled into WIDTH-bit
// words in either order; finished words are parked in a single-entry output
// register with a valid/ready handshake and a sticky overrun flag.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low; clears all state
//   sin      in   serial data bit
//   sen      in   bit strobe; sin is sampled when high
//   dir      in   word bit order: 0 = LSB first, 1 = MSB first
//                 (sampled on the first bit of each word only)
//   abort    in   synchronous; drops the partially assembled word
//   dready   in   downstream accepts dout while dvalid is high
//   ovr_clr  in   synchronous clear of overrun
//   dout     out  last completed word
//   dvalid   out  dout holds an unconsumed word
//   overrun  out  sticky; a completed word was dropped
//   bitcnt   out  bits already received in the current word
// -----------------------------------------------------------------------------
module usr_deser #(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sen,
  input  logic             dir,
  input  logic             abort,
  input  logic             dready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             overrun,
  output logic [CW-1:0]    bitcnt
);

  logic [WIDTH-1:0] sh_reg, sh_next;
  logic [CW-1:0]    bitcnt_reg, bitcnt_next;
  logic             dir_q_reg, dir_q_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic             dvalid_reg, dvalid_next;
  logic             overrun_reg, overrun_next;

  // Both candidate shift results, built bit by bit.
  //   shr_word: LSB-first stream, new bit enters at the top and moves down.
  //   shl_word: MSB-first stream, new bit enters at the bottom and moves up.
  logic [WIDTH-1:0] shr_word;
  logic [WIDTH-1:0] shl_word;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_shr_top
        assign shr_word[gi] = sin;
      end else begin : g_shr_mid
        assign shr_word[gi] = sh_reg[gi+1];
      end
      if (gi == 0) begin : g_shl_bot
        assign shl_word[gi] = sin;
      end else begin : g_shl_mid
        assign shl_word[gi] = sh_reg[gi-1];
      end
    end
  endgenerate

  logic             first_bit;
  logic             eff_dir;
  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] word;

  always_comb begin
    first_bit = (bitcnt_reg == '0);
    // The first bit of a word uses the live dir; later bits use the latched one
    // so a mid-word change of dir cannot scramble the word.
    eff_dir   = first_bit ? dir : dir_q_reg;
    accept    = sen && !abort;
    complete  = accept && (bitcnt_reg == CW'(WIDTH - 1));
    word      = eff_dir ? shl_word : shr_word;
  end

  always_comb begin
    sh_next      = sh_reg;
    bitcnt_next  = bitcnt_reg;
    dir_q_next   = dir_q_reg;
    dout_next    = dout_reg;
    dvalid_next  = dvalid_reg;
    overrun_next = overrun_reg && !ovr_clr;

    // Assembly side
    if (abort) begin
      sh_next     = '0;
      bitcnt_next = '0;
    end else if (sen) begin
      sh_next     = word;
      bitcnt_next = complete ? '0 : bitcnt_reg + CW'(1);
      if (first_bit) begin
        dir_q_next = dir;
      end
    end

    // Output buffer: a transfer in the same cycle frees the slot for the new word
    if (complete) begin
      if (!dvalid_reg || dready) begin
        dout_next   = word;
        dvalid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;  // set beats a simultaneous ovr_clr
      end
    end else if (dvalid_reg && dready) begin
      dvalid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_reg      <= '0;
      bitcnt_reg  <= '0;
      dir_q_reg   <= 1'b0;
      dout_reg    <= '0;
      dvalid_reg  <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      sh_reg      <= sh_next;
      bitcnt_reg  <= bitcnt_next;
      dir_q_reg   <= dir_q_next;
      dout_reg    <= dout_next;
      dvalid_reg  <= dvalid_next;
      overrun_reg <= overrun_next;
    end
  end

  assign dout    = dout_reg;
  assign dvalid  = dvalid_reg;
  assign overrun = overrun_reg;
  assign bitcnt  = bitcnt_reg;

endmodule

// File: tb/tb_usr_deser.sv
module tb_usr_deser;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          reset;
  logic          sin;
  logic          sen;
  logic          dir;
  logic          abort;
  logic          dready;
  logic          ovr_clr;
  logic [W-1:0]  dout;
  logic          dvalid;
  logic          overrun;
  logic [CW-1:0] bitcnt;

  usr_deser #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .sin     (sin),
    .sen     (sen),
    .dir     (dir),
    .abort   (abort),
    .dready  (dready),
    .ovr_clr (ovr_clr),
    .dout    (dout),
    .dvalid  (dvalid),
    .overrun (overrun),
    .bitcnt  (bitcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: list of bits received so far plus the order chosen by the
  // first bit; a word is formed by weighting each bit by its arrival position.
  int           q_bits[$];
  logic         m_dir;
  logic [W-1:0] m_dout;
  logic         m_dvalid;
  logic         m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_bits.delete();
    m_dir    = 1'b0;
    m_dout   = '0;
    m_dvalid = 1'b0;
    m_ovr    = 1'b0;
  endtask

  task automatic model_step(input logic b, input logic s, input logic d,
                            input logic ab, input logic rdy, input logic oc);
    logic         done;
    logic         set;
    int           wv;
    done = 1'b0;
    set  = 1'b0;
    wv   = 0;
    if (ab) begin
      q_bits.delete();
    end else if (s) begin
      if (q_bits.size() == 0) m_dir = d;
      q_bits.push_back(int'(b));
      if (q_bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          if (m_dir) wv += q_bits[i] * (1 << (W - 1 - i));
          else       wv += q_bits[i] * (1 << i);
        end
        done = 1'b1;
        q_bits.delete();
      end
    end
    if (done) begin
      if (!m_dvalid || rdy) begin
        m_dout   = W'(wv);
        m_dvalid = 1'b1;
        $display("word %0h order %0d loaded", wv, m_dir);
      end else begin
        set = 1'b1;
        $display("word %0h order %0d dropped (overrun)", wv, m_dir);
      end
    end else if (m_dvalid && rdy) begin
      m_dvalid = 1'b0;
      $display("word %0h transferred", m_dout);
    end
    m_ovr = set || (m_ovr && !oc);
  endtask

  // One clock cycle: drive inputs, clock, advance model, compare all outputs.
  task automatic tick(input logic b, input logic s, input logic d,
                      input logic ab, input logic rdy, input logic oc);
    sin = b; sen = s; dir = d; abort = ab; dready = rdy; ovr_clr = oc;
    @(posedge clk);
    model_step(b, s, d, ab, rdy, oc);
    #1;
    check("dout",    32'(dout),    32'(m_dout));
    check("dvalid",  32'(dvalid),  32'(m_dvalid));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("bitcnt",  32'(bitcnt),  32'(q_bits.size()));
  endtask

  task automatic send_word(input logic [W-1:0] val, input logic d, input logic rdy_last);
    logic [W-1:0] v;
    v = val;
    for (int i = 0; i < W; i++) begin
      tick(d ? v[W-1-i] : v[i], 1'b1, d, 1'b0, (i == W - 1) ? rdy_last : 1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    sin = 0; sen = 0; dir = 0; abort = 0; dready = 0; ovr_clr = 0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout",    32'(dout),    32'h0);
    check("rst_dvalid",  32'(dvalid),  32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_bitcnt",  32'(bitcnt),  32'h0);
    reset = 1'b1;

    // LSB first
    send_word(4'b1101, 1'b0, 1'b0);
    check("lsb_dout",   32'(dout),   32'hD);
    check("lsb_dvalid", 32'(dvalid), 32'h1);
    check("lsb_bitcnt", 32'(bitcnt), 32'h0);
    drain();

    // MSB first, gaps, dir toggled after first bit
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("msb_dout",   32'(dout),   32'hB);
    check("msb_dvalid", 32'(dvalid), 32'h1);
    drain();

    // Overrun and clear
    send_word(4'hA, 1'b0, 1'b0);
    send_word(4'h5, 1'b0, 1'b0);
    check("ovr_dout", 32'(dout),    32'hA);
    check("ovr_set",  32'(overrun), 32'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_clr",      32'(overrun), 32'h0);
    check("ovr_clr_dout", 32'(dout),    32'hA);
    drain();

    // Transfer and completion on the same edge
    send_word(4'h3, 1'b0, 1'b0);
    check("sim_hold", 32'(dout), 32'h3);
    send_word(4'hC, 1'b0, 1'b1);
    check("sim_dout",    32'(dout),    32'hC);
    check("sim_dvalid",  32'(dvalid),  32'h1);
    check("sim_overrun", 32'(overrun), 32'h0);
    drain();

    // Abort with a strobe in the same cycle
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("abort_bitcnt", 32'(bitcnt), 32'h0);
    check("abort_dvalid", 32'(dvalid), 32'h0);
    send_word(4'h6, 1'b0, 1'b0);
    check("abort_dout", 32'(dout), 32'h6);
    drain();

    // Reset between edges mid-word with a word pending
    send_word(4'h7, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_bitcnt", 32'(bitcnt), 32'h2);
    check("pre_rst_dvalid", 32'(dvalid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_dout",    32'(dout),    32'h0);
    check("arst_dvalid",  32'(dvalid),  32'h0);
    check("arst_overrun", 32'(overrun), 32'h0);
    check("arst_bitcnt",  32'(bitcnt),  32'h0);
    model_reset();
    #2;
    reset = 1'b1;
    send_word(4'h9, 1'b0, 1'b0);
    check("post_rst_dout",   32'(dout),   32'h9);
    check("post_rst_dvalid", 32'(dvalid), 32'h1);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      tick(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
